execute_stage: RTL and testbench

Execute stage of the pipelined Y86-64 processor. Consumes the E pipeline register written by decode/writeback, computes the ALU result and branch/move condition, holds the condition-code register, and drives the M pipeline register for the memory stage. It also provides `e_valE`/`e_dstE` combinationally for decode forwarding.

---
 rtl/execute_stage.sv | 145 ++++++++++++++
 tb/tb_execute_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition evaluation, condition-code register and M pipeline register.
// Optional macro EXEC_IFUN_CHECK_EN turns undefined OPq/cmov/jXX function codes into INS status.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:3]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic        M_bubble,
    input  logic [0:3]  m_stat,
    input  logic [0:3]  W_stat,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [0:3]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);
    localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8;
    localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB, R_NONE = 4'hF;
    localparam logic [0:3] S_AOK = 4'b1000, S_INS = 4'b0001;

    function automatic logic cond_eval(input logic [3:0] fn, input logic zf, input logic sf,
                                       input logic of);
        case (fn)
            4'h0:    cond_eval = 1'b1;
            4'h1:    cond_eval = (sf ^ of) | zf;
            4'h2:    cond_eval = sf ^ of;
            4'h3:    cond_eval = zf;
            4'h4:    cond_eval = !zf;
            4'h5:    cond_eval = !(sf ^ of);
            4'h6:    cond_eval = !(sf ^ of) & !zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic signed [63:0] alu_a_p0, alu_b_p0, alu_res_p0;
    logic        [3:0]  alu_fun_p0;
    logic               alu_of_p0;
    logic               ifun_bad_p0;
    logic               set_cc_p0;
    logic        [0:3]  stat_p0;

    always_comb begin
        alu_a_p0 = 64'sd0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a_p0 = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_p0 = E_valC;
            I_CALL, I_PUSHQ:             alu_a_p0 = -64'sd8;
            I_RET, I_POPQ:               alu_a_p0 = 64'sd8;
            default:                     alu_a_p0 = 64'sd0;
        endcase
        alu_b_p0 = 64'sd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b_p0 = E_valB;
            default:                                                   alu_b_p0 = 64'sd0;
        endcase
    end

    // Undefined function codes yield a zero result with all overflow cleared.
    always_comb begin
        alu_fun_p0 = (E_icode == I_OPQ) ? E_ifun : 4'h0;
        alu_res_p0 = 64'sd0;
        alu_of_p0  = 1'b0;
        case (alu_fun_p0)
            4'h0: begin
                alu_res_p0 = alu_b_p0 + alu_a_p0;
                alu_of_p0  = (alu_a_p0[63] == alu_b_p0[63]) && (alu_res_p0[63] != alu_a_p0[63]);
            end
            4'h1: begin
                alu_res_p0 = alu_b_p0 - alu_a_p0;
                alu_of_p0  = (alu_a_p0[63] != alu_b_p0[63]) && (alu_res_p0[63] != alu_b_p0[63]);
            end
            4'h2:    alu_res_p0 = alu_b_p0 & alu_a_p0;
            4'h3:    alu_res_p0 = alu_b_p0 ^ alu_a_p0;
            default: alu_res_p0 = 64'sd0;
        endcase
    end

`ifdef EXEC_IFUN_CHECK_EN
    assign ifun_bad_p0 = ((E_icode == I_OPQ) && (E_ifun > 4'd3)) ||
                         (((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) && (E_ifun > 4'd6));
`else
    assign ifun_bad_p0 = 1'b0;
`endif

    assign e_Cnd     = cond_eval(E_ifun, ZF, SF, OF);
    assign e_valE    = ifun_bad_p0 ? 64'd0 : alu_res_p0;
    assign e_dstE    = (ifun_bad_p0 || ((E_icode == I_RRMOVQ) && !e_Cnd)) ? R_NONE : E_dstE;
    assign stat_p0   = ifun_bad_p0 ? S_INS : E_stat;
    // Flags must not change once an exception is on its way through memory/writeback.
    assign set_cc_p0 = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK) && !ifun_bad_p0;

    // ---- stage boundary: E -> M register and condition codes ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= 64'd0;
            M_valA  <= 64'd0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
            ZF      <= 1'b1;
            SF      <= 1'b0;
            OF      <= 1'b0;
        end else begin
            if (set_cc_p0) begin
                ZF <= (e_valE == 64'd0);
                SF <= e_valE[63];
                OF <= alu_of_p0;
            end
            if (M_bubble) begin
                M_stat  <= S_AOK;
                M_icode <= I_NOP;
                M_Cnd   <= 1'b0;
                M_valE  <= 64'd0;
                M_valA  <= 64'd0;
                M_dstE  <= R_NONE;
                M_dstM  <= R_NONE;
            end else begin
                M_stat  <= stat_p0;
                M_icode <= E_icode;
                M_Cnd   <= e_Cnd;
                M_valE  <= e_valE;
                M_valA  <= E_valA;
                M_dstE  <= e_dstE;
                M_dstM  <= E_dstM;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected M-register contents are queued at drive time and popped after each edge.
module tb_execute_stage;
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_exp_t;

    localparam logic [3:0] AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010, INS = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:3]  E_stat = AOK;
    logic [3:0]  E_icode = 4'h1, E_ifun = 4'h0;
    logic [63:0] E_valC = '0, E_valA = '0, E_valB = '0;
    logic [3:0]  E_dstE = 4'hF, E_dstM = 4'hF;
    logic        M_bubble = 1'b0;
    logic [0:3]  m_stat = AOK, W_stat = AOK;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd, ZF, SF, OF;
    logic [0:3]  M_stat;

    int checks = 0;
    int errors = 0;
    m_exp_t sb[$];

    execute_stage dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .ZF(ZF), .SF(SF), .OF(OF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_m(input string tag, input m_exp_t e);
        check({tag, ".M_stat"},  64'(M_stat),  64'(e.stat));
        check({tag, ".M_icode"}, 64'(M_icode), 64'(e.icode));
        check({tag, ".M_Cnd"},   64'(M_Cnd),   64'(e.cnd));
        check({tag, ".M_valE"},  M_valE,       e.valE);
        check({tag, ".M_valA"},  M_valA,       e.valA);
        check({tag, ".M_dstE"},  64'(M_dstE),  64'(e.dstE));
        check({tag, ".M_dstM"},  64'(M_dstM),  64'(e.dstM));
    endtask

    task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
        check({tag, ".cc"}, 64'({ZF, SF, OF}), 64'({z, s, o}));
    endtask

    task automatic drive(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] valC, input logic [63:0] valA, input logic [63:0] valB,
                         input logic [3:0] dstE, input logic [3:0] dstM);
        E_stat = stat; E_icode = icode; E_ifun = ifun; E_valC = valC;
        E_valA = valA; E_valB = valB; E_dstE = dstE; E_dstM = dstM;
        #1;
    endtask

    task automatic check_e(input string tag, input logic [63:0] valE, input logic [3:0] dstE,
                           input logic cnd);
        check({tag, ".e_valE"}, e_valE, valE);
        check({tag, ".e_dstE"}, 64'(e_dstE), 64'(dstE));
        check({tag, ".e_Cnd"},  64'(e_Cnd), 64'(cnd));
    endtask

    task automatic push(input logic [3:0] stat, input logic [3:0] icode, input logic cnd,
                        input logic [63:0] valE, input logic [63:0] valA, input logic [3:0] dstE,
                        input logic [3:0] dstM);
        m_exp_t e;
        e = '{stat: stat, icode: icode, cnd: cnd, valE: valE, valA: valA, dstE: dstE, dstM: dstM};
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        m_exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_m(tag, e);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset raised between edges must take effect immediately.
        #2 rst = 1'b1;
        #1;
        check_m("reset_async", '{stat: AOK, icode: 4'h1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                                 dstE: 4'hF, dstM: 4'hF});
        check_cc("reset_async", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // OPq add overflowing into the sign bit
        drive(AOK, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF);
        check_e("add_ovf", 64'h8000_0000_0000_0000, 4'h3, 1'b1);
        push(AOK, 4'h6, 1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 4'hF);
        tick("add_ovf");
        check_cc("add_ovf", 1'b0, 1'b1, 1'b1);

        // OPq sub equal operands; cond le evaluated on pre-update CC (SF=OF=1, ZF=0)
        drive(AOK, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h4, 4'hF);
        check_e("sub_eq", 64'd0, 4'h4, 1'b0);
        push(AOK, 4'h6, 1'b0, 64'd0, 64'd5, 4'h4, 4'hF);
        tick("sub_eq");
        check_cc("sub_eq", 1'b1, 1'b0, 1'b0);

        // cmovne sees ZF=1 from the preceding OPq
        drive(AOK, 4'h2, 4'h4, 64'd0, 64'h55, 64'd0, 4'h2, 4'hF);
        check_e("cmovne", 64'h55, 4'hF, 1'b0);
        push(AOK, 4'h2, 1'b0, 64'h55, 64'h55, 4'hF, 4'hF);
        tick("cmovne");
        check_cc("cmovne", 1'b1, 1'b0, 1'b0);

        drive(AOK, 4'hA, 4'h0, 64'd0, 64'h77, 64'h100, 4'h4, 4'hF);
        check_e("pushq", 64'hF8, 4'h4, 1'b1);
        push(AOK, 4'hA, 1'b1, 64'hF8, 64'h77, 4'h4, 4'hF);
        tick("pushq");
        check_cc("pushq", 1'b1, 1'b0, 1'b0);

        drive(AOK, 4'hB, 4'h0, 64'd0, 64'h100, 64'h100, 4'h4, 4'h5);
        check_e("popq", 64'h108, 4'h4, 1'b1);
        push(AOK, 4'hB, 1'b1, 64'h108, 64'h100, 4'h4, 4'h5);
        tick("popq");
        check_cc("popq", 1'b1, 1'b0, 1'b0);

        // xor with an exception downstream must leave CC untouched
        m_stat = ADR;
        drive(AOK, 4'h6, 4'h3, 64'd0, 64'd1, 64'd0, 4'h3, 4'hF);
        check_e("xor_gated", 64'd1, 4'h3, 1'b1);
        push(AOK, 4'h6, 1'b1, 64'd1, 64'd1, 4'h3, 4'hF);
        tick("xor_gated");
        check_cc("xor_gated", 1'b1, 1'b0, 1'b0);

        m_stat = AOK;
        M_bubble = 1'b1;
        drive(AOK, 4'h3, 4'h0, 64'h99, 64'd0, 64'd0, 4'h6, 4'hF);
        check_e("irmovq", 64'h99, 4'h6, 1'b1);
        push(AOK, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick("bubble");
        M_bubble = 1'b0;

        drive(AOK, 4'h6, 4'h3, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 4'h3, 4'hF);
        check_e("xor_neg", 64'h8000_0000_0000_0000, 4'h3, 1'b1);
        push(AOK, 4'h6, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h3, 4'hF);
        tick("xor_neg");
        check_cc("xor_neg", 1'b0, 1'b1, 1'b0);

        drive(AOK, 4'h7, 4'h2, 64'h400, 64'h123, 64'd0, 4'hF, 4'hF);
        check_e("jl", 64'd0, 4'hF, 1'b1);
        push(AOK, 4'h7, 1'b1, 64'd0, 64'h123, 4'hF, 4'hF);
        tick("jl");

        drive(AOK, 4'h7, 4'h6, 64'h400, 64'h123, 64'd0, 4'hF, 4'hF);
        check_e("jg", 64'd0, 4'hF, 1'b0);
        push(AOK, 4'h7, 1'b0, 64'd0, 64'h123, 4'hF, 4'hF);
        tick("jg");

        // Undefined OPq function code
        drive(AOK, 4'h6, 4'h7, 64'd0, 64'd3, 64'd4, 4'h3, 4'hF);
`ifdef EXEC_IFUN_CHECK_EN
        check_e("opq_bad", 64'd0, 4'hF, 1'b0);
        push(INS, 4'h6, 1'b0, 64'd0, 64'd3, 4'hF, 4'hF);
        tick("opq_bad");
        check_cc("opq_bad", 1'b0, 1'b1, 1'b0);
`else
        check_e("opq_bad", 64'd0, 4'h3, 1'b0);
        push(AOK, 4'h6, 1'b0, 64'd0, 64'd3, 4'h3, 4'hF);
        tick("opq_bad");
        check_cc("opq_bad", 1'b1, 1'b0, 1'b0);
`endif

        // Status passes through unchanged
        drive(HLT, 4'h2, 4'h0, 64'd0, 64'h42, 64'd0, 4'h7, 4'hF);
        check_e("rrmovq_hlt", 64'h42, 4'h7, 1'b1);
        push(HLT, 4'h2, 1'b1, 64'h42, 64'h42, 4'h7, 4'hF);
        tick("rrmovq_hlt");

        // Reset mid-stream discards the instruction sitting in E
        drive(AOK, 4'h6, 4'h0, 64'd0, 64'd9, 64'd9, 4'h1, 4'hF);
        rst = 1'b1;
        #1;
        check_m("reset_mid", '{stat: AOK, icode: 4'h1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                               dstE: 4'hF, dstM: 4'hF});
        check_cc("reset_mid", 1'b1, 1'b0, 1'b0);
        push(AOK, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick("reset_hold");
        check_cc("reset_hold", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
